// File: rtl/serial_mult_ctrl.sv
// Bit-serial unsigned WA x WB shift-and-add multiplier.
// One full adder is time-shared across all partial-product bits.
// Each row (one multiplier bit) takes WA+1 cycles, so latency is fixed.

// Single-bit full adder; the only arithmetic element touching data.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_mult_ctrl #(
  parameter int WA = 3,
  parameter int WB = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [WA-1:0]   a_in,
  input  logic [WB-1:0]   b_in,
  output logic            ready,
  output logic            done,
  output logic [WA+WB-1:0] product
);

  localparam int PW = WA + WB;
  localparam int IW = $clog2(WA + 1);
  localparam int JW = (WB > 1) ? $clog2(WB) : 1;
  localparam int XW = $clog2(PW);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [WA-1:0]  r_a;
  logic [WB-1:0]  r_b;
  logic [PW-1:0]  r_acc, w_acc_nxt;
  logic           r_carry;
  logic [IW-1:0]  r_i;
  logic [JW-1:0]  r_j;
  logic [PW-1:0]  r_product;

  logic [XW-1:0]  w_p;
  logic           w_abit, w_bbit, w_accbit;
  logic           w_fa_b, w_sum, w_cout;
  logic           w_row_end, w_last;

  // Bit position p = i + j; counters are the only '+' users.
  assign w_p       = XW'(r_i) + XW'(r_j);
  assign w_row_end = (r_i == IW'(WA));
  assign w_last    = w_row_end && (r_j == JW'(WB - 1));

  // Operand bit selection via explicit muxes so out-of-range i (== WA) yields 0.
  always_comb begin
    w_abit   = 1'b0;
    w_bbit   = 1'b0;
    w_accbit = 1'b0;
    for (int k = 0; k < WA; k++)
      if (r_i == IW'(k)) w_abit = r_a[k];
    for (int k = 0; k < WB; k++)
      if (r_j == JW'(k)) w_bbit = r_b[k];
    for (int k = 0; k < PW; k++)
      if (w_p == XW'(k)) w_accbit = r_acc[k];
  end

  // Extra (WA-th) cycle of each row only flushes the carry into acc[p].
  assign w_fa_b = w_row_end ? 1'b0 : (w_abit & w_bbit);

  full_adder u_fa (
    .i_a    (w_accbit),
    .i_b    (w_fa_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Accumulator with bit p replaced by the adder sum; also feeds product on the last step.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int k = 0; k < PW; k++)
      if (w_p == XW'(k)) w_acc_nxt[k] = w_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_ADD;
      end
      S_ADD: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one adder step per ADD cycle, result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
          end
        end
        S_ADD: begin
          r_acc <= w_acc_nxt;
          if (w_row_end) begin
            r_carry <= 1'b0;
            r_i     <= '0;
            if (w_last) begin
              r_j       <= '0;
              r_product <= w_acc_nxt;
            end else begin
              r_j <= r_j + JW'(1);
            end
          end else begin
            r_carry <= w_cout;
            r_i     <= r_i + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Self-checking bench for serial_mult_ctrl (3x2 default widths).
module tb_serial_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] a_in;
  logic [1:0] b_in;
  logic       ready;
  logic       done;
  logic [4:0] product;

  int n_total = 0;
  int n_pass  = 0;

  serial_mult_ctrl #(.WA(3), .WB(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [1:0] b;
    logic [4:0] p;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // One isolated transaction; checks latency, pulse count, busy window and result.
  task automatic do_op(input logic [2:0] a, input logic [1:0] b, input int exp);
    int done_cyc;
    int ndone;
    int busy_bad;
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = 3'($urandom);
    b_in  = 2'($urandom);
    done_cyc = -1; ndone = 0; busy_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done) begin ndone++; done_cyc = c; end
      if (c <= 9 && ready) busy_bad = 1;
      if (c == 10) chk("ready_back", int'(ready), 1);
      if (c < 10) tick();
    end
    chk("done_cycle", done_cyc, 9);
    chk("done_count", ndone, 1);
    chk("busy_window", busy_bad, 0);
    chk("product", int'(product), exp);
  endtask

  initial begin
    vec_t vecs[4];
    int   ndone, done_cyc, last_done, got, ra, rb;
    int   expq[$];
    int   k;

    vecs[0] = '{a: 3'd7, b: 2'd3, p: 5'd21};
    vecs[1] = '{a: 3'd5, b: 2'd0, p: 5'd0};
    vecs[2] = '{a: 3'd0, b: 2'd3, p: 5'd0};
    vecs[3] = '{a: 3'd6, b: 2'd1, p: 5'd6};

    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;

    // Reset held two cycles, then idle with start low.
    tick(); tick();
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    reset = 1'b0;
    a_in = 3'd5; b_in = 2'd3;
    tick(); tick(); tick();
    chk("idle_ready", int'(ready), 1);
    chk("idle_done", int'(done), 0);
    chk("idle_product", int'(product), 0);

    // Directed vector table.
    for (int v = 0; v < 4; v++) do_op(vecs[v].a, vecs[v].b, int'(vecs[v].p));

    // Product held after completion.
    tick(); tick();
    chk("hold_product", int'(product), 6);

    // Randomized against the arithmetic reference a*b.
    for (int r = 0; r < 16; r++) begin
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 3));
      do_op(3'(ra), 2'(rb), ra * rb);
    end

    // Start while busy is ignored.
    a_in = 3'd6; b_in = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; done_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin ndone++; done_cyc = c; end
      if (c == 4) begin start = 1'b1; a_in = 3'd1; b_in = 2'd1; end
      if (c == 5) start = 1'b0;
      tick();
    end
    chk("busy_start_count", ndone, 1);
    chk("busy_start_cycle", done_cyc, 9);
    chk("busy_start_product", int'(product), 12);

    // Reset mid-operation aborts.
    a_in = 3'd7; b_in = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 4; c++) begin
      if (done) ndone++;
      if (c == 4) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_product", int'(product), 0);
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    do_op(3'd3, 2'd2, 6);

    // Exhaustive back-to-back with start held high.
    k = 0; ndone = 0; last_done = -1;
    start = 1'b1;
    for (int c = 0; c < 600 && ndone < 32; c++) begin
      if (done) begin
        if (expq.size() > 0) begin
          got = expq.pop_front();
          chk("exh_product", int'(product), got);
        end else chk("exh_unexpected_done", 1, 0);
        if (last_done >= 0) chk("exh_spacing", c - last_done, 10);
        last_done = c;
        ndone++;
      end
      if (ready && k < 32) begin
        a_in = 3'(k >> 2);
        b_in = 2'(k & 3);
        expq.push_back((k >> 2) * (k & 3));
        k++;
      end else begin
        if (ready) start = 1'b0;
        a_in = 3'($urandom);
        b_in = 2'($urandom);
      end
      tick();
    end
    start = 1'b0;
    chk("exh_done_total", ndone, 32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
